nibble_add_sched: RTL and testbench
===================================

NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W each  operands.
REQ-007 req0_sub / req1_sub  input  1 each  1 = a-b, 0 = a+b.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer takes result.
REQ-010 rsp_id  output  1  index of requester owning the result.
REQ-011 rsp_sum  output  W  result mod 2^W.
REQ-012 rsp_cout  output  1  final carry; for sub, 1 = no borrow.
REQ-013 busy  output  1  high in RUN and DONE.

Function
REQ-014 FSM states IDLE, RUN, DONE; one shared 4-bit adder slice, one nibble per cycle.
REQ-015 IDLE: if any reqN_valid, grant exactly one; reqN_ready = 1 combinationally for the granted requester only, in IDLE only.
REQ-016 Arbitration round-robin: pointer selects priority; a lone requester is always granted; after each grant, pointer points to the other requester.
REQ-017 On acceptance, latch a, b (inverted if sub), sub, id; carry register = sub; nibble index = 0; go to RUN.
REQ-018 RUN cycle k: slice adds a[4k+3:4k] + b'[4k+3:4k] + carry; sum nibble stored at position k, carry register updated, k incremented.
REQ-019 After NIBBLES RUN cycles, go to DONE; rsp_cout = final carry.
REQ-020 Latency: rsp_valid rises exactly NIBBLES+1 clocks after the accepting edge (IDLE to RUN edge counts as 1).
REQ-021 DONE: rsp_valid = 1; rsp_sum, rsp_cout, rsp_id held stable until rsp_ready = 1.
REQ-022 DONE with rsp_ready = 1: return to IDLE next edge; no acceptance in that same cycle (both reqN_ready = 0 in RUN and DONE).
REQ-023 rsp_valid = 0 outside DONE; rsp_sum/rsp_cout retain last values and are valid only with rsp_valid.
REQ-024 Request inputs are ignored outside IDLE; a requester dropping valid before being granted loses nothing.

Reset
REQ-025 rst asserted: immediately state = IDLE, rsp_valid = 0, busy = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, carry = 0, pointer = requester 0.
REQ-026 While rst asserted, req0_ready = req1_ready = 0.
REQ-027 Reset during RUN or DONE discards the operation; no result is ever produced for it.

Structure
REQ-028 Shared package holds the NIBBLES default, the state encoding (IDLE, RUN, DONE) and the requester id constants.
REQ-029 One sub-module: the existing 4-bit ripple-carry adder fulladdR, instantiated once as the shared slice; no other arithmetic.

Verification
REQ-030 req0 add a=0x1234 b=0x0FFF -> rsp_sum=0x2233, rsp_cout=0, rsp_id=0, rsp_valid 5 clocks after accept.
REQ-031 req1 add a=0xFFFF b=0x0001 -> rsp_sum=0x0000, rsp_cout=1 (carry through all 4 nibbles).
REQ-032 Sub a=0x0005 b=0x0007 -> 0xFFFE, cout=0; sub a=0x0007 b=0x0005 -> 0x0002, cout=1.
REQ-033 Both valid continuously from reset, rsp_ready=1 -> grants 0,1,0,1; each grant gap = 6 clocks; ready never high for both.
REQ-034 rsp_ready held 0 for 3 cycles in DONE -> rsp_* stable, busy=1, both reqN_ready=0; release -> IDLE next edge.
REQ-035 rst pulsed mid-RUN (after 2 nibbles) -> outputs at reset values at once, no rsp_valid afterwards, next grant goes to req0.

Source files
------------

// File: rtl/nibble_add_sched_pkg.sv
// Shared definitions for the nibble-serial add/subtract scheduler:
// default slice count, FSM state encoding and requester identifiers.
package nibble_add_sched_pkg;

  localparam int NIBBLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/nibble_add_sched_fulladdr.sv
// 4-bit ripple-carry adder slice; the only arithmetic in the scheduler.
module fulladdR (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_bit
    assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_add_sched.sv
// Two-requester add/subtract unit. A round-robin arbiter accepts one
// operation in IDLE, a single shared 4-bit slice processes it one nibble
// per cycle in RUN, and the result is held in DONE until consumed.
module nibble_add_sched
  import nibble_add_sched_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_sub,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          r_state;
  logic            r_ptr;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            r_id;
  logic            r_rsp_valid;
  logic            r_busy;
  logic [IW-1:0]   r_idx;

  logic            w_gnt_id;
  logic            w_accept;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic            w_sel_sub;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_slice_sum;
  logic            w_slice_cout;
  logic [W-1:0]    w_acc_next;
  logic            w_last;

  // Round-robin pick: pointer breaks ties, a lone requester always wins.
  always_comb begin
    w_gnt_id = ID_REQ0;
    if (req0_valid && req1_valid) begin
      w_gnt_id = r_ptr;
    end else if (req1_valid) begin
      w_gnt_id = ID_REQ1;
    end
  end

  // Acceptance only happens in IDLE; ready is additionally masked during reset.
  assign w_accept   = (r_state == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !rst && (w_gnt_id == ID_REQ0);
  assign req1_ready = w_accept && !rst && (w_gnt_id == ID_REQ1);

  assign w_sel_a   = (w_gnt_id == ID_REQ1) ? req1_a   : req0_a;
  assign w_sel_b   = (w_gnt_id == ID_REQ1) ? req1_b   : req0_b;
  assign w_sel_sub = (w_gnt_id == ID_REQ1) ? req1_sub : req0_sub;

  assign w_a_nib = r_a[4*r_idx +: 4];
  assign w_b_nib = r_b[4*r_idx +: 4];
  assign w_last  = (r_idx == IW'(NIBBLES - 1));

  fulladdR u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Accumulator with the current nibble merged into its slot.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[4*r_idx +: 4] = w_slice_sum;
  end

  // Control FSM with registered response/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= ID_REQ0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_sum       <= '0;
      r_id        <= ID_REQ0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id    <= w_gnt_id;
            r_ptr   <= ~w_gnt_id;
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            r_carry <= w_sel_sub;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_sum       <= w_acc_next;
            r_cout      <= w_slice_cout;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand and partial-result storage; no reset needed, always written before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= w_sel_a;
      r_b <= w_sel_sub ? ~w_sel_b : w_sel_b;
    end
    if (r_state == ST_RUN) begin
      r_acc <= w_acc_next;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Bench for nibble_add_sched: transaction-level reference model checked
// every cycle, plus directed operations with literal expected values.
module tb_nibble_add_sched;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  nibble_add_sched #(.NIBBLES(NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic bit pick(input bit v0, input bit v1, input bit p);
    if (v0 && v1) return p;
    return v1;
  endfunction

  // Reference model: one operation in flight, result ready NIB edges after acceptance.
  bit           m_idle = 1'b1, m_done = 1'b0, m_ptr = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_sum = '0, m_sum_pend = '0;
  bit           m_cout = 1'b0, m_cout_pend = 1'b0, m_id = 1'b0, m_id_pend = 1'b0;

  initial forever begin
    logic [W-1:0] a, b;
    bit g, s;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_idle = 1'b1; m_done = 1'b0; m_ptr = 1'b0; m_cnt = 0;
      m_sum = '0; m_cout = 1'b0; m_id = 1'b0;
    end else if (m_idle) begin
      if (req0_valid || req1_valid) begin
        g = pick(req0_valid, req1_valid, m_ptr);
        a = g ? req1_a : req0_a;
        b = g ? req1_b : req0_b;
        s = g ? req1_sub : req0_sub;
        if (s) begin
          m_sum_pend  = a - b;
          m_cout_pend = (a >= b);
        end else begin
          {m_cout_pend, m_sum_pend} = {1'b0, a} + {1'b0, b};
        end
        m_id_pend = g;
        m_ptr     = !g;
        m_idle    = 1'b0;
        m_cnt     = NIB;
      end
    end else if (!m_done) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_sum  = m_sum_pend;
        m_cout = m_cout_pend;
        m_id   = m_id_pend;
      end
    end else if (rsp_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  initial forever begin
    bit e_acc, e_g;
    @(negedge clk);
    if (chk_en) begin
      e_g   = pick(req0_valid, req1_valid, m_ptr);
      e_acc = m_idle && !rst && (req0_valid || req1_valid);
      chk("m_rdy0",  req0_ready, e_acc && !e_g);
      chk("m_rdy1",  req1_ready, e_acc && e_g);
      chk("m_valid", rsp_valid, m_done);
      chk("m_busy",  busy, !m_idle);
      chk("m_sum",   rsp_sum, m_sum);
      chk("m_cout",  rsp_cout, m_cout);
      if (m_done || rst) chk("m_id", rsp_id, m_id);
    end
  end

  // One operation through requester r; hold keeps rsp_ready low for 3 DONE cycles.
  task automatic op(input bit r, input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                    input logic [W-1:0] es, input bit ec, input bit hold, input string nm);
    bit got;
    int n;
    rsp_ready = !hold;
    if (r) begin req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1'b1; end
    else   begin req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1'b1; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = r ? req1_ready : req0_ready;
    end
    chk({nm, "_grant"}, got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      got = rsp_valid;
    end
    chk({nm, "_lat"},  n, NIB + 1);
    chk({nm, "_sum"},  rsp_sum, es);
    chk({nm, "_cout"}, rsp_cout, ec);
    chk({nm, "_id"},   rsp_id, r);
    if (hold) begin
      req1_a = 16'h0003; req1_b = 16'h0004; req1_sub = 1'b0; req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk({nm, "_hsum"},  rsp_sum, es);
        chk({nm, "_hcout"}, rsp_cout, ec);
        chk({nm, "_hval"},  rsp_valid, 1);
        chk({nm, "_hbusy"}, busy, 1);
        chk({nm, "_hrdy0"}, req0_ready, 0);
        chk({nm, "_hrdy1"}, req1_ready, 0);
      end
      rsp_ready = 1'b1; req1_valid = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_rel_val"},  rsp_valid, 0);
      chk({nm, "_rel_busy"}, busy, 0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit got, seen;
    int ng, both;
    int gid[8];
    int gt[8];
    int cyc;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_rdy0",  req0_ready, 0);
    chk("rst_rdy1",  req1_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_sum",   rsp_sum, 0);
    chk("rst_cout",  rsp_cout, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add0");
    op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "addc");
    op(1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "subb");
    op(1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, "subn");
    op(1'b0, 16'hA5A5, 16'h1111, 1'b0, 16'hB6B6, 1'b0, 1'b1, "hold");

    // Abort an operation after two nibbles with an asynchronous reset.
    req1_a = 16'h1111; req1_b = 16'h2222; req1_sub = 1'b0; req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req1_ready;
    end
    chk("abort_grant", got, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    req0_a = 16'h0001; req0_b = 16'h0002; req0_sub = 1'b0;
    req1_a = 16'h0010; req1_b = 16'h0001; req1_sub = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("ab_valid", rsp_valid, 0);
    chk("ab_busy",  busy, 0);
    chk("ab_sum",   rsp_sum, 16'hB6B6 & 16'h0000);
    chk("ab_cout",  rsp_cout, 0);
    chk("ab_id",    rsp_id, 0);
    chk("ab_rdy0",  req0_ready, 0);
    chk("ab_rdy1",  req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("ab_no_rsp", seen, 0);

    // Both requesters continuously valid: alternating grants, fixed spacing.
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ng = 0; both = 0; cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both++;
      if ((req0_ready || req1_ready) && ng < 8) begin
        gid[ng] = req1_ready ? 1 : 0;
        gt[ng]  = cyc;
        ng++;
      end
      cyc++;
    end
    chk("rr_count", (ng >= 4) ? 1 : 0, 1);
    chk("rr_both",  both, 0);
    chk("rr_g0", gid[0], 0);
    chk("rr_g1", gid[1], 1);
    chk("rr_g2", gid[2], 0);
    chk("rr_g3", gid[3], 1);
    chk("rr_gap1", gt[1] - gt[0], 6);
    chk("rr_gap2", gt[2] - gt[1], 6);
    chk("rr_gap3", gt[3] - gt[2], 6);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    gid_init: for (int i = 0; i < 1; i++) begin end
  end

endmodule
